// File: rtl/uart_pkg.sv
// Shared types for the configurable UART receiver.
// The BREAK state only exists when UART_RX_BREAK_DET_EN is defined.
package uart_pkg;

    localparam int SYNC_STAGES = 2;

`ifdef UART_RX_BREAK_DET_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`endif

    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_t;

    // 2'b11 is treated the same as 2'b00 (no parity).
    function automatic parity_t decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'b01:   return PAR_ODD;
            2'b10:   return PAR_EVEN;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver: a 2-flop synchroniser followed by
// a 3-deep vote history that is advanced on every oversample tick.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic s_tick,
    input  logic rx,
    output logic rxs,
    output logic vote
);

    logic [SYNC_STAGES-1:0] sync;
    logic [2:0]             hist;

    // Both the synchroniser and the history reset to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
            hist <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx};
            if (s_tick) begin
                hist <= {hist[1:0], sync[SYNC_STAGES-1]};
            end
        end
    end

    assign rxs  = sync[SYNC_STAGES-1];
    assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with runtime parity/stop selection and a
// valid/ready holding register. Break detection is enabled by UART_RX_BREAK_DET_EN.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tick,
    input  logic                 rx,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_break
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BIW = $clog2(DATA_BITS);
    localparam logic [TCW-1:0] TC_HALF = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] TC_FULL = TCW'(OVERSAMPLE - 1);
    localparam logic [BIW-1:0] BI_LAST = BIW'(DATA_BITS - 1);

    rx_state_t              state, state_next;
    logic [TCW-1:0]         tc;
    logic [BIW-1:0]         bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shreg;
    parity_t                par_mode;
    logic                   stop2_lat;
    logic                   par_err_int;
    logic                   frame_err_int;
    logic                   rxs;
    logic                   vote;
    logic                   at_half;
    logic                   at_full;
    logic                   complete;

    uart_rx_sampler u_sampler (
        .clk    (clk),
        .rst    (rst),
        .s_tick (s_tick),
        .rx     (rx),
        .rxs    (rxs),
        .vote   (vote)
    );

    assign at_half = s_tick && (tc == TC_HALF);
    assign at_full = s_tick && (tc == TC_FULL);

`ifdef UART_RX_BREAK_DET_EN
    logic par_bit;
    logic is_break;
    logic brk_det;
    // A break is an all-zero frame whose first stop bit is also zero.
    assign is_break = !stop_idx && !vote && (shreg == '0) && !par_bit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        complete   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_det    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (s_tick && !rxs) state_next = START;
            end
            START: begin
                if (at_half) state_next = vote ? IDLE : DATA;
            end
            DATA: begin
                if (at_full && (bit_idx == BI_LAST)) begin
                    state_next = (par_mode != PAR_NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_full) state_next = STOP;
            end
            STOP: begin
                if (at_full) begin
`ifdef UART_RX_BREAK_DET_EN
                    if (is_break) begin
                        brk_det    = 1'b1;
                        state_next = BREAK;
                    end else
`endif
                    if (stop_idx || !stop2_lat) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            BREAK: begin
                if (s_tick && rxs) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // tc restarts on every state change and wraps at each bit centre.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc <= '0;
        end else if (state_next != state) begin
            tc <= '0;
        end else if (s_tick && (state == START || state == DATA ||
                                state == PARITY || state == STOP)) begin
            tc <= (tc == TC_FULL) ? '0 : tc + TCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            shreg         <= '0;
            par_mode      <= PAR_NONE;
            stop2_lat     <= 1'b0;
            par_err_int   <= 1'b0;
            frame_err_int <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (s_tick && !rxs) begin
                        par_mode      <= decode_parity(cfg_parity);
                        stop2_lat     <= cfg_stop2;
                        bit_idx       <= '0;
                        stop_idx      <= 1'b0;
                        par_err_int   <= 1'b0;
                        frame_err_int <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                        par_bit       <= 1'b0;
`endif
                    end
                end
                DATA: begin
                    if (at_full) begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BIW'(1);
                    end
                end
                PARITY: begin
                    if (at_full) begin
                        par_err_int <= ((^shreg) ^ vote) != (par_mode == PAR_ODD);
`ifdef UART_RX_BREAK_DET_EN
                        par_bit     <= vote;
`endif
                    end
                end
                STOP: begin
                    if (at_full) begin
                        stop_idx <= 1'b1;
                        if (!vote) frame_err_int <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A pop coinciding with a completion makes room, so the new frame loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete && (!rx_valid || rx_ready)) begin
                rx_data    <= shreg;
                rx_valid   <= 1'b1;
                parity_err <= par_err_int;
                frame_err  <= frame_err_int | !vote;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_break <= 1'b0;
        end else begin
            rx_break <= brk_det;
        end
    end
`else
    assign rx_break = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: frames are built from plain line-level
// rules, expectations queued at send time and checked by a separate monitor.
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] cfg_parity = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       rx_break;

    int errors = 0;
    int checks = 0;
    int exp_overrun = 0;
    int ovr_cnt = 0;
    int exp_break = 0;
    int brk_cnt = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tick     (s_tick),
        .rx         (rx),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .rx_break   (rx_break)
    );

    // Clock and one-in-four oversample strobe
    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            s_tick = (cnt == 0);
            cnt = (cnt + 1) % 4;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: expected flags from counting ones and inspecting stop levels.
    task automatic send_frame(input logic [7:0] data, input logic [1:0] par,
                              input logic parbit, input logic stop2,
                              input logic [1:0] stopv, input bit deliver,
                              input int flip_bit);
        logic perr;
        logic ferr;
        int   ones;
        cfg_parity = par;
        cfg_stop2  = stop2;
        step(4);
        ones = $countones(data) + int'(parbit);
        perr = 1'b0;
        if (par == 2'b01) perr = (ones % 2 == 0);
        else if (par == 2'b10) perr = (ones % 2 == 1);
        ferr = !stopv[0] || (stop2 && !stopv[1]);
        if (deliver) exp_q.push_back({data, perr, ferr});
        else exp_overrun++;
        rx = 1'b0;
        step(64);
        for (int i = 0; i < 8; i++) begin
            if (i == flip_bit) begin
                rx = data[i];  step(26);
                rx = ~data[i]; step(4);
                rx = data[i];  step(34);
            end else begin
                rx = data[i];
                step(64);
            end
        end
        if (par == 2'b01 || par == 2'b10) begin
            rx = parbit;
            step(64);
        end
        for (int s = 0; s < (stop2 ? 2 : 1); s++) begin
            if (stopv[s]) begin
                rx = 1'b1; step(64);
            end else begin
                rx = 1'b0; step(44);
                rx = 1'b1; step(20);
            end
        end
        rx = 1'b1;
        step($urandom_range(80, 40));
    endtask

    // Monitor: pops and compares whenever the consumer side completes a transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (overrun) ovr_cnt++;
            if (rx_break) brk_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got data 0x%0h pe %0b fe %0b, none expected",
                             rx_data, parity_err, frame_err);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(mon_exp[9:2]));
                    check("parity_err", 32'(parity_err), 32'(mon_exp[1]));
                    check("frame_err", 32'(frame_err), 32'(mon_exp[0]));
                end
            end
        end
    end

    initial begin
        logic [1:0] sv;
        step(3);
        check("reset_valid", 32'(rx_valid), 0);
        check("reset_data", 32'(rx_data), 0);
        check("reset_flags", {29'd0, parity_err, frame_err, overrun}, 0);
        rst = 1'b0;
        step(40);

        send_frame(8'h37, 2'b00, 1'b0, 1'b0, 2'b11, 1, -1);
        send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 2'b11, 1, -1);

        send_frame(8'h5A, 2'b10, 1'b0, 1'b0, 2'b11, 1, -1);
        send_frame(8'h5A, 2'b10, 1'b1, 1'b0, 2'b11, 1, -1);
        send_frame(8'h5A, 2'b01, 1'b1, 1'b0, 2'b11, 1, -1);

        send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 2'b01, 1, -1);
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        rx = 1'b0; step(20);
        rx = 1'b1; step(200);
        check("glitch_no_valid", 32'(rx_valid), 0);

        rx_ready = 1'b0;
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 2'b11, 1, -1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 2'b11, 0, -1);
        check("overrun_held_valid", 32'(rx_valid), 1);
        check("overrun_held_data", 32'(rx_data), 32'h11);
        check("overrun_pulses", ovr_cnt, exp_overrun);
        rx_ready = 1'b1;
        step(3);
        check("pop_clears_valid", 32'(rx_valid), 0);

        send_frame(8'hC3, 2'b00, 1'b0, 1'b0, 2'b11, 1, 3);
        send_frame(8'hC3, 2'b10, 1'b0, 1'b0, 2'b11, 1, 6);

        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        step(4);
        rx = 1'b0; step(64);
        rx = 1'b1; step(64 * 3);
        rst = 1'b1; step(3);
        rst = 1'b0; step(900);
        check("rst_mid_no_valid", 32'(rx_valid), 0);
        send_frame(8'h81, 2'b00, 1'b0, 1'b0, 2'b11, 1, -1);

`ifdef UART_RX_BREAK_DET_EN
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        step(4);
        rx = 1'b0; step(768);
        rx = 1'b1;
        exp_break++;
        step(200);
        check("break_no_valid", 32'(rx_valid), 0);
        send_frame(8'h42, 2'b00, 1'b0, 1'b0, 2'b11, 1, -1);
`endif

        for (int n = 0; n < 12; n++) begin
            sv[0] = ($urandom_range(3, 0) != 0);
            sv[1] = ($urandom_range(3, 0) != 0);
            send_frame(8'($urandom_range(255, 1)), 2'($urandom_range(3, 0)),
                       1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), sv, 1,
                       ($urandom_range(1, 0) != 0) ? int'($urandom_range(7, 0)) : -1);
        end

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) step(1);
        check("queue_drained", exp_q.size(), 0);
        check("overrun_total", ovr_cnt, exp_overrun);
        check("break_total", brk_cnt, exp_break);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
